// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - next-PC sequencer: PC source select, fetch gating, traps and post-redirect annul
module pc_ctrl #(
    parameter int RESET_HOLD      = 4,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       imem_ready,
    input  logic       illop,
    input  logic       is_jump,
    input  logic       is_branch,
    input  logic       br_taken,
    input  logic       supervisor,
    input  logic       irq,
    output logic [2:0] pcsel,
    output logic       pc_en,
    output logic       xp_wr,
    output logic       irq_ack,
    output logic       annul,
    output logic       irq_pending
);

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] SEL_INC    = 3'd0;
    localparam logic [2:0] SEL_OFFSET = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_ILLOP  = 3'd3;
    localparam logic [2:0] SEL_XADR   = 3'd4;
    localparam logic [7:0] HOLD_LAST  = 8'(RESET_HOLD - 1);

    state_t                     state;
    logic [7:0]                 hold_cnt;
    logic [IRQ_SYNC_STAGES-1:0] irq_sync;
    logic                       irq_last_d;
    logic                       irq_rise;

    assign irq_rise = irq_sync[IRQ_SYNC_STAGES-1] & ~irq_last_d;

    // PC source decode; only a RUN cycle with a valid instruction word may redirect.
    always_comb begin
        pcsel   = SEL_INC;
        pc_en   = 1'b0;
        xp_wr   = 1'b0;
        irq_ack = 1'b0;
        case (state)
            RUN: begin
                if (imem_ready) begin
                    pc_en = 1'b1;
                    if (illop) begin
                        pcsel = SEL_ILLOP;
                        xp_wr = 1'b1;
                    end else if (irq_pending && !supervisor) begin
                        pcsel   = SEL_XADR;
                        xp_wr   = 1'b1;
                        irq_ack = 1'b1;
                    end else if (is_jump) begin
                        pcsel = SEL_JUMP;
                    end else if (is_branch && br_taken) begin
                        pcsel = SEL_OFFSET;
                    end
                end
            end
            FLUSH: begin
                pc_en = imem_ready;
            end
            default: begin
                pc_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= 8'd0;
            irq_sync    <= '0;
            irq_last_d  <= 1'b0;
            irq_pending <= 1'b0;
            annul       <= 1'b1;
        end else begin
            irq_sync   <= {irq_sync[IRQ_SYNC_STAGES-2:0], irq};
            irq_last_d <= irq_sync[IRQ_SYNC_STAGES-1];
            // A fresh edge wins over a take so a back-to-back request is not lost.
            if (irq_rise) begin
                irq_pending <= 1'b1;
            end else if (irq_ack) begin
                irq_pending <= 1'b0;
            end

            case (state)
                HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (hold_cnt == HOLD_LAST) begin
                        state <= RUN;
                        annul <= 1'b0;
                    end else begin
                        annul <= 1'b1;
                    end
                end
                RUN: begin
                    if (imem_ready) begin
                        if (pcsel != SEL_INC) begin
                            state <= FLUSH;
                            annul <= 1'b1;
                        end else begin
                            annul <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (imem_ready) begin
                        state <= RUN;
                        annul <= 1'b0;
                    end else begin
                        annul <= 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                    annul <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed and randomized checks of pc_ctrl against a behavioural model
module tb_pc_ctrl;

    localparam int RESET_HOLD      = 4;
    localparam int IRQ_SYNC_STAGES = 2;

    logic       clock = 1'b0;
    logic       reset, imem_ready, illop, is_jump, is_branch, br_taken, supervisor, irq;
    logic [2:0] pcsel;
    logic       pc_en, xp_wr, irq_ack, annul, irq_pending;

    int checks = 0;
    int errors = 0;

    pc_ctrl #(.RESET_HOLD(RESET_HOLD), .IRQ_SYNC_STAGES(IRQ_SYNC_STAGES)) dut (
        .clock(clock), .reset(reset), .imem_ready(imem_ready), .illop(illop),
        .is_jump(is_jump), .is_branch(is_branch), .br_taken(br_taken),
        .supervisor(supervisor), .irq(irq), .pcsel(pcsel), .pc_en(pc_en),
        .xp_wr(xp_wr), .irq_ack(irq_ack), .annul(annul), .irq_pending(irq_pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model: cycles of hold left, whether a redirect still owes an annulled fetch,
    // the pending flag, and recent irq samples for edge detection.
    bit m_ok = 1'b0;
    int m_hold;
    bit m_flush;
    bit m_pend;
    bit irq_q[$];

    always @(negedge clock) begin
        bit       in_hold, e_en, e_xp, e_ack, rise;
        logic [2:0] e_sel;
        in_hold = (m_hold > 0);
        e_sel = 3'd0; e_en = 1'b0; e_xp = 1'b0; e_ack = 1'b0;
        if (in_hold) begin
            e_en = 1'b0;
        end else if (m_flush) begin
            e_en = imem_ready;
        end else if (imem_ready) begin
            e_en = 1'b1;
            if (illop) begin
                e_sel = 3'd3; e_xp = 1'b1;
            end else if (m_pend && !supervisor) begin
                e_sel = 3'd4; e_xp = 1'b1; e_ack = 1'b1;
            end else if (is_jump) begin
                e_sel = 3'd2;
            end else if (is_branch && br_taken) begin
                e_sel = 3'd1;
            end
        end
        if (m_ok) begin
            chk("m_pcsel", pcsel, e_sel);
            chk("m_pc_en", pc_en, e_en);
            chk("m_xp_wr", xp_wr, e_xp);
            chk("m_irq_ack", irq_ack, e_ack);
            chk("m_annul", annul, in_hold || m_flush);
            chk("m_irq_pending", irq_pending, m_pend);
        end
        if (reset) begin
            m_ok = 1'b1;
            m_hold = RESET_HOLD;
            m_flush = 1'b0;
            m_pend = 1'b0;
            irq_q = {};
            for (int i = 0; i <= IRQ_SYNC_STAGES; i++) irq_q.push_back(1'b0);
        end else if (m_ok) begin
            rise = irq_q[IRQ_SYNC_STAGES-1] && !irq_q[IRQ_SYNC_STAGES];
            if (rise) m_pend = 1'b1;
            else if (e_ack) m_pend = 1'b0;
            irq_q.push_front(irq);
            void'(irq_q.pop_back());
            if (in_hold) m_hold = m_hold - 1;
            else if (m_flush) m_flush = !imem_ready;
            else if (imem_ready) m_flush = (e_sel != 3'd0);
        end
    end

    initial begin
        reset = 1'b1; imem_ready = 1'b1; illop = 1'b0; is_jump = 1'b0;
        is_branch = 1'b0; br_taken = 1'b0; supervisor = 1'b0; irq = 1'b0;

        @(negedge clock);
        chk("rst_annul", annul, 1); chk("rst_pc_en", pc_en, 0);
        chk("rst_pend", irq_pending, 0); chk("rst_pcsel", pcsel, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < RESET_HOLD; i++) begin
            @(negedge clock);
            chk("hold_pc_en", pc_en, 0); chk("hold_annul", annul, 1);
        end
        @(negedge clock);
        chk("run_pc_en", pc_en, 1); chk("run_pcsel", pcsel, 0); chk("run_annul", annul, 0);

        step(); is_branch = 1'b1; br_taken = 1'b1;
        @(negedge clock); chk("br_pcsel", pcsel, 1); chk("br_pc_en", pc_en, 1);
        step(); is_branch = 1'b0; br_taken = 1'b0; is_jump = 1'b1;
        @(negedge clock); chk("br_fl_annul", annul, 1); chk("br_fl_pcsel", pcsel, 0);
        chk("br_fl_pc_en", pc_en, 1);
        step(); is_jump = 1'b0;
        @(negedge clock); chk("br_after_annul", annul, 0);

        step(); supervisor = 1'b1; irq = 1'b1;
        @(negedge clock); chk("irq_pend_0", irq_pending, 0);
        for (int i = 1; i <= IRQ_SYNC_STAGES; i++) begin
            step(); @(negedge clock);
            chk("irq_pend_early", irq_pending, 0); chk("irq_ack_sup", irq_ack, 0);
        end
        step(); @(negedge clock); chk("irq_pend_set", irq_pending, 1); chk("irq_ack_sup", irq_ack, 0);
        step(); illop = 1'b1;
        @(negedge clock); chk("sup_illop_pcsel", pcsel, 3); chk("sup_illop_xp", xp_wr, 1);
        step(); illop = 1'b0;
        @(negedge clock); chk("sup_fl_annul", annul, 1); chk("sup_fl_pcsel", pcsel, 0);
        step();
        @(negedge clock); chk("sup_mask_ack", irq_ack, 0); chk("sup_mask_pend", irq_pending, 1);

        step(); supervisor = 1'b0; illop = 1'b1; is_jump = 1'b1;
        @(negedge clock); chk("prio_pcsel", pcsel, 3); chk("prio_xp", xp_wr, 1); chk("prio_ack", irq_ack, 0);
        step(); illop = 1'b0; is_jump = 1'b0;
        @(negedge clock); chk("prio_fl_ack", irq_ack, 0); chk("prio_fl_pend", irq_pending, 1);
        step();
        @(negedge clock); chk("take_pcsel", pcsel, 4); chk("take_ack", irq_ack, 1); chk("take_xp", xp_wr, 1);
        step();
        @(negedge clock); chk("take_pend_clr", irq_pending, 0);

        step(); irq = 1'b0; is_jump = 1'b1; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); chk("stall_pc_en", pc_en, 0); chk("stall_pcsel", pcsel, 0);
            step();
        end
        imem_ready = 1'b1;
        @(negedge clock); chk("jmp_pcsel", pcsel, 2); chk("jmp_pc_en", pc_en, 1);
        step(); is_jump = 1'b0; imem_ready = 1'b0;
        @(negedge clock); chk("fl_stall_annul", annul, 1); chk("fl_stall_pc_en", pc_en, 0);
        step();
        @(negedge clock); chk("fl_stall_annul", annul, 1); chk("fl_stall_pc_en", pc_en, 0);
        step(); imem_ready = 1'b1;
        @(negedge clock); chk("fl_end_annul", annul, 1); chk("fl_end_pc_en", pc_en, 1);
        step();
        @(negedge clock); chk("fl_done_annul", annul, 0);

        step(); supervisor = 1'b1; irq = 1'b1;
        repeat (IRQ_SYNC_STAGES + 1) step();
        @(negedge clock); chk("rf_pend", irq_pending, 1);
        step(); is_jump = 1'b1;
        @(negedge clock); chk("rf_jmp", pcsel, 2);
        step(); is_jump = 1'b0; imem_ready = 1'b0;
        @(negedge clock); chk("rf_in_flush", annul, 1);
        step(); reset = 1'b1;
        @(negedge clock);
        step(); reset = 1'b0; imem_ready = 1'b1; irq = 1'b0; supervisor = 1'b0;
        @(negedge clock);
        chk("rf_pend_lost", irq_pending, 0); chk("rf_annul", annul, 1); chk("rf_pc_en", pc_en, 0);

        for (int n = 0; n < 4000; n++) begin
            step();
            reset      = ($urandom_range(0, 199) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            illop      = ($urandom_range(0, 15) == 0);
            is_jump    = ($urandom_range(0, 7) == 0);
            is_branch  = ($urandom_range(0, 3) == 0);
            br_taken   = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) supervisor = ~supervisor;
            if ($urandom_range(0, 7) == 0) irq = ~irq;
        end

        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Next-PC sequencer for the Beta-style PC register. Each cycle it chooses the PC source (pcsel), gates PC loads on instruction-memory readiness, and takes illegal-op and external-interrupt traps. The PC register loads only when pc_en=1. It also holds the PC after reset, annuls the instruction fetched after any non-sequential PC change, and strobes the XP register write on traps.

Parameters:
RESET_HOLD, 4, cycles after reset deassertion with pc_en=0 (range 1..255)
IRQ_SYNC_STAGES, 2, flops in the irq synchronizer chain (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
imem_ready  in  1  instruction word for current PC is valid this cycle
illop  in  1  decoded instruction is illegal
is_jump  in  1  decoded JMP
is_branch  in  1  decoded BEQ/BNE
br_taken  in  1  branch condition true (valid with is_branch)
supervisor  in  1  PC[31]; 1 = kernel mode, interrupts masked
irq  in  1  external interrupt, asynchronous, level
pcsel  out  3  0 inc, 1 offset, 2 jump target, 3 ILLOP, 4 XADR
pc_en  out  1  PC register load enable
xp_wr  out  1  write pc_inc into XP (trap entry)
irq_ack  out  1  one-cycle pulse when the interrupt is taken
annul  out  1  current instruction is discarded (no register write, no memory write)
irq_pending  out  1  latched interrupt request

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. All state changes on rising edge of clock.
- Reset values: state=HOLD, hold counter=0, synchronizer flops=0, pending=0, annul=1. Combinational outputs in HOLD: pcsel=0, pc_en=0, xp_wr=0, irq_ack=0.
- pcsel, pc_en, xp_wr and irq_ack are combinational from state and inputs, valid in the same cycle. annul and irq_pending are registered.
- States: HOLD, RUN, FLUSH.
- HOLD:
  - Counter increments each cycle; annul=1; pc_en=0.
  - When counter==RESET_HOLD-1, go to RUN next cycle.
- RUN with imem_ready=0: pc_en=0, pcsel=0, xp_wr=0. Stay in RUN; annul unchanged. Decode inputs are ignored.
- RUN with imem_ready=1: pc_en=1. First match in priority order wins:
  1. illop: pcsel=3, xp_wr=1.
  2. pending & !supervisor: pcsel=4, xp_wr=1, irq_ack=1, pending cleared.
  3. is_jump: pcsel=2.
  4. is_branch & br_taken: pcsel=1.
  5. otherwise: pcsel=0.
- RUN transitions: if pcsel!=0 and pc_en=1, go to FLUSH and set annul=1. Otherwise stay in RUN and set annul=0.
- FLUSH:
  - annul=1; decode inputs (illop, jump, branch) and interrupts are ignored; pcsel=0; pc_en=imem_ready.
  - When imem_ready=1, go to RUN with annul cleared. Otherwise remain in FLUSH.
- Interrupt synchronization:
  - irq passes through IRQ_SYNC_STAGES flops.
  - A rising edge of the last stage (compared with a one-flop delayed copy) sets pending.
  - Pending holds until taken or reset.
  - A new edge in the same cycle as a take leaves pending=1.
  - An interrupt is never taken in HOLD or FLUSH, or while supervisor=1. It stays pending.
- illop during supervisor=1 is still taken (pcsel=3).
- Reset mid-operation (any state, any cycle): return to HOLD with reset values. The pending interrupt is lost.
- pcsel values 5..7 are never driven.

Test Plan:
- Reset held 3 cycles, then released, RESET_HOLD=4, imem_ready=1 -> pc_en=0 and annul=1 for exactly 4 cycles after release; cycle 5 pc_en=1, pcsel=0.
- RUN, imem_ready=1, is_branch=1, br_taken=1 -> pcsel=1, pc_en=1; next cycle annul=1, pcsel=0 even with is_jump=1; following cycle annul=0.
- RUN, illop=1 and is_jump=1 and pending=1 together, supervisor=0 -> pcsel=3, xp_wr=1, irq_ack=0; pending stays 1 and is taken at the first RUN cycle after FLUSH (pcsel=4, irq_ack=1).
- irq raised while supervisor=1 -> irq_pending=1 exactly IRQ_SYNC_STAGES+1 cycles later; no take. supervisor drops to 0 -> take on the next RUN cycle with imem_ready=1, then irq_pending=0.
- imem_ready low for 3 cycles during RUN with is_jump=1 -> pc_en=0 for 3 cycles; jump taken (pcsel=2) on the cycle imem_ready=1; imem_ready low in FLUSH extends FLUSH.
- reset asserted in FLUSH with pending=1 -> next cycle state HOLD, irq_pending=0, annul=1, pc_en=0.
